add256_operand_loader: RTL and testbench

ADD256_OPERAND_LOADER -- requirements
Module: add256_operand_loader

---
 rtl/add256_pkg.sv | 16 +
 rtl/add256_operand_loader.sv | 127 ++++++++++++
 tb/tb_add256_operand_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add256_pkg.sv
// Shared sizing and FSM state encoding for the 256-bit adder operand loader.
package add256_pkg;

  localparam int N     = 256;
  localparam int W     = 32;
  localparam int WORDS = N / W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/add256_operand_loader.sv
// Streams two N-bit operands in W-bit words, presents them to an external adder and holds the result.
// Optional macro ADD256_LOADER_ABORT_EN adds an abort input that restarts loading without clearing data.
module add256_operand_loader #(
  parameter int N = add256_pkg::N,
  parameter int W = add256_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         cin_in,
`ifdef ADD256_LOADER_ABORT_EN
  input  logic         abort,
`endif
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         cin,
  output logic         op_valid,
  input  logic [N-1:0] s,
  input  logic         cout,
  output logic [N-1:0] res_s,
  output logic         res_cout,
  output logic         res_valid,
  input  logic         res_ready
);

  localparam int WORDS = N / W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  add256_pkg::state_t state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       a_q, b_q, res_s_q;
  logic               cin_q, res_cout_q, ready_en_q;
  logic               xfer, abort_hit;

`ifdef ADD256_LOADER_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // ready_en_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = ready_en_q &&
                     ((state_q == add256_pkg::LOAD_A) || (state_q == add256_pkg::LOAD_B));
  assign xfer      = in_valid && in_ready;
  assign op_valid  = (state_q == add256_pkg::EXEC);
  assign res_valid = (state_q == add256_pkg::HOLD);

  assign a        = a_q;
  assign b        = b_q;
  assign cin      = cin_q;
  assign res_s    = res_s_q;
  assign res_cout = res_cout_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      add256_pkg::LOAD_A, add256_pkg::LOAD_B: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state_q == add256_pkg::LOAD_A) ? add256_pkg::LOAD_B : add256_pkg::EXEC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      add256_pkg::EXEC: state_d = add256_pkg::HOLD;
      add256_pkg::HOLD: begin
        if (res_ready) begin
          state_d = add256_pkg::LOAD_A;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = add256_pkg::LOAD_A;
        idx_d   = '0;
      end
    endcase
    // Abort overrides any transfer or result release in the same cycle.
    if (abort_hit) begin
      state_d = add256_pkg::LOAD_A;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= add256_pkg::LOAD_A;
      idx_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      res_s_q    <= '0;
      res_cout_q <= 1'b0;
    end else begin
      if (xfer && !abort_hit) begin
        if (state_q == add256_pkg::LOAD_A) begin
          a_q[idx_q*W +: W] <= in_data;
          if (idx_q == '0) begin
            cin_q <= cin_in;
          end
        end else begin
          b_q[idx_q*W +: W] <= in_data;
        end
      end
      if (state_q == add256_pkg::EXEC) begin
        res_s_q    <= s;
        res_cout_q <= cout;
      end
    end
  end

endmodule

// File: tb/tb_add256_operand_loader.sv
// Directed bench for add256_operand_loader with a behavioural stand-in for the parent's adder.
// Define ADD256_LOADER_ABORT_EN to also exercise the abort input.
module tb_add256_operand_loader;

  localparam int N     = 256;
  localparam int W     = 32;
  localparam int WORDS = N / W;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         cin_in;
  logic [N-1:0] a, b, s, res_s;
  logic         cin, cout, op_valid, res_cout, res_valid, res_ready;
  logic [N:0]   sumFull;
`ifdef ADD256_LOADER_ABORT_EN
  logic         abort;
`endif

  int compared   = 0;
  int mismatched = 0;

  add256_operand_loader #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cin_in    (cin_in),
`ifdef ADD256_LOADER_ABORT_EN
    .abort     (abort),
`endif
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_valid  (op_valid),
    .s         (s),
    .cout      (cout),
    .res_s     (res_s),
    .res_cout  (res_cout),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  // Stand-in for the carry-select adder the parent places between a/b/cin and s/cout.
  assign sumFull = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign s       = sumFull[N-1:0];
  assign cout    = sumFull[N];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drives the first 'count' words of the A-then-B stream; all driving happens on falling edges.
  task automatic sendWords(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv,
                           input int count, input bit gaps, output bit tmo);
    tmo = 1'b0;
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = (i < WORDS) ? av[i*W +: W] : bv[(i-WORDS)*W +: W];
      cin_in   = (i == 0) ? cv : ~cv;
      for (int t = 0; !in_ready && t < 50; t++) @(negedge clk);
      if (!in_ready) begin
        tmo      = 1'b1;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic releaseResult();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cin_in = 1'b0; res_ready = 1'b0;
`ifdef ADD256_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    compared++;
    if ({a, b, cin, res_s, res_cout, op_valid, res_valid, in_ready} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: a=%h b=%h cin=%b res_s=%h res_cout=%b opv=%b resv=%b rdy=%b expected all 0",
               a, b, cin, res_s, res_cout, op_valid, res_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ready_after_edge: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    bit tmo;
    sendWords(256'd1, 256'd1, 1'b0, 2*WORDS, 1'b0, tmo);
    compared++;
    if (tmo || op_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic_exec: timeout=%b op_valid=%b expected 0/1", tmo, op_valid);
    end
    @(negedge clk);
    compared++;
    if (res_valid !== 1'b1 || res_s !== 256'd2 || res_cout !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_sum: got v=%b s=%h c=%b expected v=1 s=2 c=0", res_valid, res_s, res_cout);
    end
    releaseResult();
    // Carry out of word 0 into word 1.
    sendWords(256'hFFFF_FFFF, 256'd1, 1'b0, 2*WORDS, 1'b0, tmo);
    @(negedge clk);
    compared++;
    if (tmo || res_s !== 256'h1_0000_0000 || res_cout !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL word_carry: got s=%h c=%b expected s=100000000 c=0", res_s, res_cout);
    end
    releaseResult();
  endtask

  task automatic test_carry();
    bit tmo;
    sendWords({N{1'b1}}, '0, 1'b1, 2*WORDS, 1'b0, tmo);
    compared++;
    if (tmo || a !== {N{1'b1}} || b !== '0 || cin !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL carry_operands: timeout=%b cin=%b a=%h expected cin=1 a=all ones", tmo, cin, a);
    end
    @(negedge clk);
    compared++;
    if (res_s !== '0 || res_cout !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL carry_sum: got s=%h c=%b expected s=0 c=1", res_s, res_cout);
    end
    releaseResult();
  endtask

  task automatic test_gaps_hold();
    bit tmo;
    logic [N-1:0] av, bv, expS;
    av   = {8{32'h1111_1111}};
    bv   = {8{32'h2222_2222}};
    expS = {{7{32'h3333_3333}}, 32'h3333_3334};
    sendWords(av, bv, 1'b1, 2*WORDS, 1'b1, tmo);
    compared++;
    if (tmo || op_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL gaps_exec: timeout=%b op_valid=%b expected 0/1", tmo, op_valid);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_s !== expS || res_cout !== 1'b0 ||
          a !== av || b !== bv || cin !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL hold_cycle%0d: v=%b rdy=%b s=%h c=%b cin=%b expected v=1 rdy=0 s=%h c=0 cin=1",
                 i, res_valid, in_ready, res_s, res_cout, cin, expS);
      end
      @(negedge clk);
    end
    releaseResult();
    in_valid = 1'b0;
    compared++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || a !== av) begin
      mismatched++;
      $display("[TB] FAIL hold_release: v=%b rdy=%b a=%h expected v=0 rdy=1 a=%h", res_valid, in_ready, a, av);
    end
  endtask

  task automatic test_reset_midload();
    bit tmo;
    sendWords({N{1'b1}}, {N{1'b1}}, 1'b1, WORDS + 3, 1'b0, tmo);
    rst = 1'b1;
    #1;
    compared++;
    if (tmo || {a, b, cin, res_s, res_cout, op_valid, res_valid, in_ready} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midload_reset: timeout=%b a=%h b=%h cin=%b res_s=%h rdy=%b expected all 0",
               tmo, a, b, cin, res_s, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sendWords(256'd5, 256'd7, 1'b0, 2*WORDS, 1'b0, tmo);
    @(negedge clk);
    compared++;
    if (tmo || res_valid !== 1'b1 || res_s !== 256'd12 || res_cout !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL after_reset_sum: got v=%b s=%h c=%b expected v=1 s=c c=0", res_valid, res_s, res_cout);
    end
    releaseResult();
  endtask

`ifdef ADD256_LOADER_ABORT_EN
  task automatic test_abort();
    bit tmo;
    logic [N-1:0] av, expB;
    av   = {8{32'hA5A5_A5A5}};
    expB = {128'd0, {4{32'h0F0F_0F0F}}};
    sendWords(av, {8{32'h0F0F_0F0F}}, 1'b0, WORDS + 4, 1'b0, tmo);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    compared++;
    if (tmo || res_valid !== 1'b0 || in_ready !== 1'b1 || a !== av || b !== expB) begin
      mismatched++;
      $display("[TB] FAIL abort_state: timeout=%b v=%b rdy=%b b=%h expected v=0 rdy=1 b=%h",
               tmo, res_valid, in_ready, b, expB);
    end
    sendWords(256'd3, 256'd4, 1'b0, 2*WORDS, 1'b0, tmo);
    @(negedge clk);
    compared++;
    if (tmo || res_valid !== 1'b1 || res_s !== 256'd7 || res_cout !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_sum: got v=%b s=%h c=%b expected v=1 s=7 c=0", res_valid, res_s, res_cout);
    end
    releaseResult();
  endtask
`endif

  function automatic logic [W-1:0] streamWord(input int k);
    int op, w;
    op = k / (2*WORDS);
    w  = k % (2*WORDS);
    if (w == 0)     return (op == 0) ? 32'd10 : (op == 1) ? 32'd100 : 32'd1;
    if (w == WORDS) return (op == 0) ? 32'd20 : (op == 1) ? 32'd200 : 32'd2;
    return '0;
  endfunction

  task automatic test_back_to_back();
    logic [N-1:0] expS [3];
    int resCyc [3];
    int k, nres;
    bit prevHold, xferNow;
    expS[0] = 256'd30; expS[1] = 256'd300; expS[2] = 256'd3;
    k = 0; nres = 0; prevHold = 1'b0;
    res_ready = 1'b1;
    cin_in    = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (prevHold) begin
        compared++;
        if (in_ready !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL b2b_ready_after_hold: cycle %0d got %b expected 1", c, in_ready);
        end
      end
      if (res_valid === 1'b1) begin
        compared++;
        if (nres >= 3 || res_s !== expS[nres]) begin
          mismatched++;
          $display("[TB] FAIL b2b_result%0d: got %h at cycle %0d", nres, res_s, c);
        end
        if (nres < 3) resCyc[nres] = c;
        nres++;
      end
      prevHold = res_valid;
      in_valid = 1'b1;
      in_data  = streamWord(k);
      xferNow  = in_ready;
      @(negedge clk);
      if (xferNow) k++;
    end
    in_valid  = 1'b0;
    res_ready = 1'b0;
    compared++;
    if (nres !== 3 || resCyc[0] !== 17 || resCyc[1] - resCyc[0] !== 18 || resCyc[2] - resCyc[1] !== 18) begin
      mismatched++;
      $display("[TB] FAIL b2b_rate: got %0d results at %0d,%0d,%0d expected 3 at 17,35,53",
               nres, resCyc[0], resCyc[1], resCyc[2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_gaps_hold();
    test_reset_midload();
`ifdef ADD256_LOADER_ABORT_EN
    test_abort();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
